// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: fill modes, FSM states, direction codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'b00,
        FILL_ONE   = 2'b01,
        FILL_ARITH = 2'b10,
        FILL_ROT   = 2'b11
    } fill_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-position shift of data, shifted-out bit collected into cout; rotate gated by SHIFT_ROT_EN.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] cout,
    input  logic             dir,
    input  logic [1:0]       fill_mode,
    output logic [WIDTH-1:0] data_nxt,
    output logic [WIDTH-1:0] cout_nxt
);

    logic fill_bit;

    // Without SHIFT_ROT_EN, mode 11 falls to the default and fills with zero.
    always_comb begin
        fill_bit = 1'b0;
        case (fill_mode)
            FILL_ONE:   fill_bit = 1'b1;
            FILL_ARITH: fill_bit = (dir == DIR_RIGHT) ? data[WIDTH-1] : 1'b0;
`ifdef SHIFT_ROT_EN
            FILL_ROT:   fill_bit = (dir == DIR_RIGHT) ? data[0] : data[WIDTH-1];
`endif
            default:    fill_bit = 1'b0;
        endcase
    end

    always_comb begin
        if (dir == DIR_RIGHT) begin
            data_nxt = {fill_bit, data[WIDTH-1:1]};
            cout_nxt = {data[0], cout[WIDTH-1:1]};
        end else begin
            data_nxt = {data[WIDTH-2:0], fill_bit};
            cout_nxt = {cout[WIDTH-2:0], data[WIDTH-1]};
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter, one bit per clock, collecting shifted-out bits; SHIFT_ROT_EN enables rotate.
// Latency: done pulses min(amt,WIDTH)+1 cycles after the accepting edge.
// Backpressure: start is only accepted in IDLE/DONE; starts during SHIFT are dropped.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       fill_mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] cout
);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] amt_clamp;
    logic [WIDTH-1:0] data_q, cout_q;
    logic [WIDTH-1:0] step_data, step_cout;
    logic             dir_q;
    logic [1:0]       fill_q;
    logic             accept, step;

    assign amt_clamp = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data      (data_q),
        .cout      (cout_q),
        .dir       (dir_q),
        .fill_mode (fill_q),
        .data_nxt  (step_data),
        .cout_nxt  (step_cout)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The count==0 cycle is a settle cycle: not busy, result already final.
                if (cnt_q != '0) begin
                    busy = 1'b1;
                    step = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            cout_q  <= '0;
            dir_q   <= DIR_LEFT;
            fill_q  <= FILL_ZERO;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= data_in;
                cout_q <= '0;
                cnt_q  <= amt_clamp;
                dir_q  <= dir;
                fill_q <= fill_mode;
            end else if (step) begin
                data_q <= step_data;
                cout_q <= step_cout;
                cnt_q  <= cnt_q - AMT_W'(1);
            end
        end
    end

    assign data_out = data_q;
    assign cout     = cout_q;

endmodule
